// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, ALU control codes,
// memory/system op encodings, decode classes and FSM states.
package alu_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [3:0] alu_ctrl_t;

    localparam opcode_t OP_ADD      = 6'd0;
    localparam opcode_t OP_SUB      = 6'd1;
    localparam opcode_t OP_MUL      = 6'd2;
    localparam opcode_t OP_AND      = 6'd3;
    localparam opcode_t OP_OR       = 6'd4;
    localparam opcode_t OP_LDB      = 6'd10;
    localparam opcode_t OP_LDW      = 6'd11;
    localparam opcode_t OP_STB      = 6'd12;
    localparam opcode_t OP_STW      = 6'd13;
    localparam opcode_t OP_MOV      = 6'd14;
    localparam opcode_t OP_BEQ      = 6'd30;
    localparam opcode_t OP_JUMP     = 6'd31;
    localparam opcode_t OP_TLBWRITE = 6'd32;
    localparam opcode_t OP_IRET     = 6'd33;

    localparam alu_ctrl_t ALU_ADD = 4'd0;
    localparam alu_ctrl_t ALU_SUB = 4'd1;
    localparam alu_ctrl_t ALU_MUL = 4'd2;
    localparam alu_ctrl_t ALU_AND = 4'd3;
    localparam alu_ctrl_t ALU_OR  = 4'd4;

    typedef enum logic [1:0] {MEM_LDB, MEM_LDW, MEM_STB, MEM_STW} mem_op_t;
    typedef enum logic       {SYS_TLBWRITE, SYS_IRET} sys_op_t;

    typedef enum logic [1:0] {B_RT, B_IMM, B_ZERO} b_sel_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_MOV, CL_MEM, CL_BEQ, CL_JUMP, CL_SYS, CL_UNDEF
    } op_class_t;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps a 6-bit opcode to the ALU control code,
// the second-operand source and the retirement class.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] op,
    output alu_ctrl_t  alu_ctrl,
    output b_sel_t     b_sel,
    output op_class_t  op_class
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        alu_ctrl = ALU_ADD;
        b_sel    = B_ZERO;
        op_class = CL_UNDEF;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
                alu_ctrl = op[3:0];
                b_sel    = B_RT;
                op_class = CL_ALU;
            end
            OP_LDB, OP_LDW, OP_STB, OP_STW: begin
                alu_ctrl = ALU_ADD;
                b_sel    = B_IMM;
                op_class = CL_MEM;
            end
            OP_MOV: begin
                alu_ctrl = ALU_OR;
                b_sel    = B_ZERO;
                op_class = CL_MOV;
            end
            OP_BEQ: begin
                alu_ctrl = ALU_SUB;
                b_sel    = B_RT;
                op_class = CL_BEQ;
            end
            OP_JUMP:              op_class = CL_JUMP;
            OP_TLBWRITE, OP_IRET: op_class = CL_SYS;
            default:              op_class = CL_UNDEF;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer driving a combinational ALU, one instruction in flight.
// Optional ALU_TRAP_EN adds a trap pulse for undefined opcodes.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            br_taken,
    output logic [XLEN-1:0] br_offset,
    output logic            mem_valid,
    output logic [1:0]      mem_op,
    output logic [XLEN-1:0] mem_addr,
    output logic            sys_valid,
    output logic            sys_op,
`ifdef ALU_TRAP_EN
    output logic            trap,
`endif
    output logic            done
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t          state, state_next;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] rs_q, rt_q, result_q;
    logic            zero_q;
    logic [CNT_W-1:0] cnt;

    opcode_t   op;
    alu_ctrl_t dec_ctrl;
    b_sel_t    dec_b_sel;
    op_class_t dec_class;
    logic [XLEN-1:0] imm_sext;
    logic      transfer;
    logic      skip_exec;

    assign op       = instr_q[31:26];
    assign rs_addr  = instr_q[25:21];
    assign rt_addr  = instr_q[20:16];
    assign imm_sext = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    assign transfer = instr_valid && (state == S_IDLE);
    assign skip_exec = (dec_class == CL_JUMP) || (dec_class == CL_SYS) ||
                       (dec_class == CL_UNDEF);

    alu_op_decode u_decode (
        .op       (op),
        .alu_ctrl (dec_ctrl),
        .b_sel    (dec_b_sel),
        .op_class (dec_class)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (transfer) state_next = S_DECODE;
            S_DECODE: state_next = skip_exec ? S_WB : S_EXEC;
            S_EXEC:   if (cnt == '0) state_next = S_WB;
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (transfer) instr_q <= instr;
            if (state == S_DECODE) begin
                rs_q <= rs_data;
                rt_q <= rt_data;
                cnt  <= (dec_class == CL_ALU && dec_ctrl == ALU_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            end
            // Result is captured on the edge that leaves EXEC, after the last hold cycle.
            if (state == S_EXEC) begin
                if (cnt == '0) begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        alu_ctrl    = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        br_taken    = 1'b0;
        br_offset   = '0;
        mem_valid   = 1'b0;
        mem_op      = '0;
        mem_addr    = '0;
        sys_valid   = 1'b0;
        sys_op      = 1'b0;
        done        = 1'b0;
`ifdef ALU_TRAP_EN
        trap        = 1'b0;
`endif
        if (state == S_EXEC) begin
            alu_ctrl = dec_ctrl;
            alu_a    = rs_q;
            case (dec_b_sel)
                B_RT:    alu_b = rt_q;
                B_IMM:   alu_b = imm_sext;
                default: alu_b = '0;
            endcase
        end
        if (state == S_WB) begin
            done = 1'b1;
            case (dec_class)
                CL_ALU, CL_MOV: begin
                    wb_en   = (instr_q[15:11] != 5'd0);
                    wb_addr = instr_q[15:11];
                    wb_data = result_q;
                end
                CL_MEM: begin
                    mem_valid = 1'b1;
                    mem_op    = 2'(op - OP_LDB);
                    mem_addr  = result_q;
                end
                CL_BEQ: begin
                    br_taken  = zero_q;
                    br_offset = imm_sext;
                end
                CL_JUMP: begin
                    br_taken  = 1'b1;
                    br_offset = imm_sext;
                end
                CL_SYS: begin
                    sys_valid = 1'b1;
                    sys_op    = op[0];
                end
                default: begin
`ifdef ALU_TRAP_EN
                    trap = 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized
// instructions scored against an instruction-level reference model.
module tb_alu_issue_ctrl;

    localparam int MUL_LAT = 3;
    localparam int XLEN    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [4:0]      rs_addr, rt_addr;
    logic [XLEN-1:0] rs_data, rt_data;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            br_taken;
    logic [XLEN-1:0] br_offset;
    logic            mem_valid;
    logic [1:0]      mem_op;
    logic [XLEN-1:0] mem_addr;
    logic            sys_valid;
    logic            sys_op;
    logic            done;
    logic            trap_w;
`ifdef ALU_TRAP_EN
    logic            trap;
    assign trap_w = trap;
`else
    assign trap_w = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .alu_ctrl(alu_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_offset(br_offset),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr),
        .sys_valid(sys_valid), .sys_op(sys_op),
`ifdef ALU_TRAP_EN
        .trap(trap),
`endif
        .done(done)
    );

    // Environment: register file and combinational ALU.
    logic [31:0] regs [32];
    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            4'd3:    alu_result = alu_a & alu_b;
            4'd4:    alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        int          lat;
        bit          uses_alu;
        int          exec_len;
        logic [3:0]  ctrl;
        logic [31:0] a, b;
        bit          wb;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        bit          mem;
        logic [1:0]  mem_op;
        logic [31:0] mem_addr;
        bit          br;
        logic [31:0] br_off;
        bit          sys;
        bit          sys_op;
        bit          trap;
    } exp_t;

    // Instruction-level semantics: what each opcode must do, and when it retires.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [5:0]  op;
        logic [31:0] rs, rt, simm;
        logic [4:0]  rd;
        op   = ins[31:26];
        rs   = regs[ins[25:21]];
        rt   = regs[ins[20:16]];
        rd   = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        e = '{default: 0};
        e.lat = 2;
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd14: begin
                e.uses_alu = 1;
                e.exec_len = (op == 6'd2) ? MUL_LAT : 1;
                e.ctrl     = (op == 6'd14) ? 4'd4 : op[3:0];
                e.a        = rs;
                e.b        = (op == 6'd14) ? 32'd0 : rt;
                e.wb       = (rd != 0);
                e.wb_addr  = rd;
                case (op)
                    6'd0:    e.wb_data = rs + rt;
                    6'd1:    e.wb_data = rs - rt;
                    6'd2:    e.wb_data = 32'(64'(rs) * 64'(rt));
                    6'd3:    e.wb_data = rs & rt;
                    6'd4:    e.wb_data = rs | rt;
                    default: e.wb_data = rs;
                endcase
            end
            6'd10, 6'd11, 6'd12, 6'd13: begin
                e.uses_alu = 1;
                e.exec_len = 1;
                e.ctrl     = 4'd0;
                e.a        = rs;
                e.b        = simm;
                e.mem      = 1;
                e.mem_op   = 2'(op - 6'd10);
                e.mem_addr = rs + simm;
            end
            6'd30: begin
                e.uses_alu = 1;
                e.exec_len = 1;
                e.ctrl     = 4'd1;
                e.a        = rs;
                e.b        = rt;
                e.br       = (rs == rt);
                e.br_off   = simm;
            end
            6'd31: begin
                e.br     = 1;
                e.br_off = simm;
            end
            6'd32, 6'd33: begin
                e.sys    = 1;
                e.sys_op = (op == 6'd33);
            end
            default: begin
`ifdef ALU_TRAP_EN
                e.trap = 1;
`endif
            end
        endcase
        if (e.uses_alu) e.lat = 2 + e.exec_len;
        return e;
    endfunction

    task automatic run_instr(input logic [31:0] ins, input bit hold_valid);
        exp_t e;
        bit   got_done;
        e = model(ins);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        for (int w = 0; w < 20 && !instr_ready; w++) @(negedge clk);
        check("ready_idle", instr_ready, 1'b1);
        @(posedge clk);
        #1;
        // A busy controller must ignore whatever the sender presents.
        if (hold_valid) instr = $urandom();
        else            instr_valid = 1'b0;
        got_done = 0;
        for (int k = 1; k <= 12 && !got_done; k++) begin
            @(negedge clk);
            if (e.uses_alu && k >= 2 && k < 2 + e.exec_len) begin
                check("alu_ctrl", alu_ctrl, e.ctrl);
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
            end
            if (done) begin
                got_done    = 1;
                instr_valid = 1'b0;
                check("latency", k, e.lat);
                check("wb_en", wb_en, e.wb);
                if (e.wb) begin
                    check("wb_addr", wb_addr, e.wb_addr);
                    check("wb_data", wb_data, e.wb_data);
                end
                check("mem_valid", mem_valid, e.mem);
                if (e.mem) begin
                    check("mem_op", mem_op, e.mem_op);
                    check("mem_addr", mem_addr, e.mem_addr);
                end
                check("br_taken", br_taken, e.br);
                if (e.br) check("br_offset", br_offset, e.br_off);
                check("sys_valid", sys_valid, e.sys);
                if (e.sys) check("sys_op", sys_op, e.sys_op);
`ifdef ALU_TRAP_EN
                check("trap", trap_w, e.trap);
`endif
            end else begin
                check("stray_pulse", {wb_en, br_taken, mem_valid, sys_valid, trap_w}, 5'b0);
                check("ready_busy", instr_ready, 1'b0);
            end
        end
        if (!got_done) begin
            check("done_timeout", 1'b0, 1'b1);
            instr_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0] ops [17] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10, 6'd11, 6'd12, 6'd13,
                             6'd14, 6'd30, 6'd31, 6'd32, 6'd33, 6'd5, 6'd20, 6'd63};

    initial begin
        int quiet;
        logic [4:0] rsn, rtn;
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", instr_ready, 1'b1);
        check("reset_pulses", {wb_en, br_taken, mem_valid, sys_valid, done}, 5'b0);
        check("reset_alu_ctrl", alu_ctrl, 4'd0);
        check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
        check("reset_wb", {wb_addr, wb_data}, 37'd0);
        check("reset_br_mem", {br_offset, mem_addr}, 64'd0);

        // Directed cases.
        regs[1] = 32'd5; regs[2] = 32'd7;
        run_instr(r_type(6'd0, 5'd1, 5'd2, 5'd3), 0);
        regs[4] = 32'h10000; regs[5] = 32'h10000;
        run_instr(r_type(6'd2, 5'd4, 5'd5, 5'd6), 0);
        regs[7] = 32'd9; regs[8] = 32'd9;
        run_instr(i_type(6'd30, 5'd7, 5'd8, 16'hFFFC), 0);
        regs[8] = 32'd8;
        run_instr(i_type(6'd30, 5'd7, 5'd8, 16'hFFFC), 0);
        regs[9] = 32'hFFFF_FFFF;
        run_instr(i_type(6'd11, 5'd9, 5'd0, 16'd2), 0);
        run_instr(i_type(6'd12, 5'd9, 5'd0, 16'd2), 0);
        run_instr(r_type(6'd0, 5'd1, 5'd2, 5'd0), 0);
        run_instr(i_type(6'd20, 5'd1, 5'd2, 16'h1234), 0);
        run_instr(i_type(6'd31, 5'd0, 5'd0, 16'h8000), 1);
        run_instr(i_type(6'd33, 5'd0, 5'd0, 16'd0), 0);

        // Reset while an ADD sits in EXEC drops it silently.
        @(negedge clk);
        instr       = r_type(6'd0, 5'd1, 5'd2, 5'd3);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", instr_ready, 1'b1);
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || wb_en) quiet++;
        end
        check("rst_drop_pulses", quiet, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            rsn = 5'($urandom());
            rtn = 5'($urandom());
            regs[rsn] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            regs[rtn] = $urandom();
            if ($urandom_range(0, 1) == 1) regs[rtn] = regs[rsn];
            run_instr(i_type(ops[$urandom_range(0, 16)], rsn, rtn, 16'($urandom())),
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
